core_step_ctrl: RTL

- Consumer end of the slow-tick interface: takes the one-cycle tick pulse produced by the clock divider and turns it into a qualified one-cycle clock-enable for the single-cycle RISC-V core.
- Supports free-run, single-step from a debounced push-button, and halt.
- Detects a lost tick source with a watchdog.
- Sits between the tick generator, board switches/buttons and the core's enable input.

---
 rtl/core_step_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/core_step_ctrl.sv
// ============================================================================
// Module   : core_step_ctrl
// Function : Turns the divider tick into a qualified one-cycle core enable
//            with free-run, debounced single-step, halt and tick watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_step_ctrl #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int TICK_TIMEOUT   = 24000000,
  parameter int CNT_W_WD       = 25,
  parameter int STEP_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              halt_req,
  output logic              core_en,
  output logic              running,
  output logic [STEP_W-1:0] step_count,
  output logic              tick_lost
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0]     DB_MAX = DB_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W_WD-1:0] WD_MAX = CNT_W_WD'(TICK_TIMEOUT);

  localparam logic [1:0] ST_HALT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STEP_ARM = 2'd2;

  logic              run_meta_q, run_s_q, btn_meta_q, btn_s_q;
  logic              db_last_q, db_last_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              btn_db_q, btn_db_d;
  logic              db_prev_q;
  logic [1:0]        state_q, state_d;
  logic              core_en_q, core_en_d;
  logic              running_q, running_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic [CNT_W_WD-1:0] wd_cnt_q, wd_cnt_d;
  logic              tick_lost_q, tick_lost_d;
  logic              step_req;

  // Debounce samples only on tick, so the filter window scales with the tick rate
  always_comb begin
    db_last_d = db_last_q;
    db_cnt_d  = db_cnt_q;
    btn_db_d  = btn_db_q;
    if (tick) begin
      db_last_d = btn_s_q;
      if (btn_s_q != db_last_q) begin
        db_cnt_d = DB_W'(1);
      end else if (db_cnt_q != DB_MAX) begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
      if ((db_cnt_d == DB_MAX) && (btn_s_q != btn_db_q)) begin
        btn_db_d = btn_s_q;
      end
    end
  end

  assign step_req = btn_db_q & ~db_prev_q;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (tick) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + CNT_W_WD'(1);
    end
    tick_lost_d = tick_lost_q | (wd_cnt_d == WD_MAX);
  end

  always_comb begin
    state_d   = state_q;
    core_en_d = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (tick_lost_q) begin
          state_d = ST_HALT;
        end else if (run_s_q && !halt_req) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP_ARM;
        end
      end
      ST_RUN: begin
        if (halt_req || !run_s_q || tick_lost_q) begin
          state_d = ST_HALT;
        end else if (tick) begin
          core_en_d = 1'b1;
        end
      end
      ST_STEP_ARM: begin
        if (halt_req || tick_lost_q) begin
          state_d = ST_HALT;
        end else if (tick) begin
          core_en_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    running_d    = (state_d == ST_RUN);
    step_count_d = core_en_d ? step_count_q + STEP_W'(1) : step_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_meta_q   <= 1'b0;
      run_s_q      <= 1'b0;
      btn_meta_q   <= 1'b0;
      btn_s_q      <= 1'b0;
      db_last_q    <= 1'b0;
      db_cnt_q     <= '0;
      btn_db_q     <= 1'b0;
      db_prev_q    <= 1'b0;
      state_q      <= ST_HALT;
      core_en_q    <= 1'b0;
      running_q    <= 1'b0;
      step_count_q <= '0;
      wd_cnt_q     <= '0;
      tick_lost_q  <= 1'b0;
    end else begin
      run_meta_q   <= run_sw;
      run_s_q      <= run_meta_q;
      btn_meta_q   <= step_btn;
      btn_s_q      <= btn_meta_q;
      db_last_q    <= db_last_d;
      db_cnt_q     <= db_cnt_d;
      btn_db_q     <= btn_db_d;
      db_prev_q    <= btn_db_q;
      state_q      <= state_d;
      core_en_q    <= core_en_d;
      running_q    <= running_d;
      step_count_q <= step_count_d;
      wd_cnt_q     <= wd_cnt_d;
      tick_lost_q  <= tick_lost_d;
    end
  end

  assign core_en    = core_en_q;
  assign running    = running_q;
  assign step_count = step_count_q;
  assign tick_lost  = tick_lost_q;

endmodule

`default_nettype wire
